// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the unified single-port I/D memory of the MIPS core.
// One access is in flight at a time; each access walks IDLE -> ISSUE -> WAIT -> RESP.
//
// Requester handshake:
//   - A requester raises its req and holds it, with address/data stable, until
//     its ready pulse.
//   - ready is a single-cycle pulse in the RESP cycle. Read data is already
//     registered and valid in that same cycle.
//   - A req still high in the IDLE cycle after RESP is treated as a fresh request.
//   - The stall outputs are req & ~ready. They freeze the fetch stage or the
//     whole pipeline until the pulse arrives.
//   - A fetch flushed during ISSUE/WAIT completes on the memory side. It gives
//     no ready pulse and leaves if_rdata untouched.
// Debug: dbg_state encodes IDLE=0, ISSUE=1, WAIT=2, RESP=3; dbg_streak is the
// current count of back-to-back data grants made while a fetch was waiting.
module mem_port_arbiter #(
  parameter int unsigned LAT        = 2,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state,
  output logic [7:0]  dbg_streak
);

  localparam logic [7:0] CNT_LOAD   = 8'(LAT - 1);
  localparam logic [7:0] STREAK_MAX = 8'(MAX_STREAK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;      // 1 = data access, 0 = fetch
  logic        drop_q, drop_d;        // in-flight fetch was flushed
  logic [7:0]  streak_q, streak_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        grant_d_req;
  logic        grant_f_req;

  // State register and all registered outputs; reset abandons any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      drop_q      <= 1'b0;
      streak_q    <= '0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state: grant in IDLE, one strobe cycle, latency countdown, response.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    streak_d    = streak_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d_req = 1'b0;
    grant_f_req = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Data wins ties until the fetch has been passed over MAX_STREAK times.
        if (d_req && (!if_req || (streak_q != STREAK_MAX))) begin
          grant_d_req = 1'b1;
        end else if (if_req) begin
          grant_f_req = 1'b1;
        end
        if (grant_d_req) begin
          owner_d     = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          streak_d    = if_req ? (streak_q + 8'd1) : 8'd0;
        end
        if (grant_f_req) begin
          owner_d     = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
        if (grant_d_req || grant_f_req) begin
          drop_d   = 1'b0;
          mem_en_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!owner_q && if_flush) drop_d = 1'b1;
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!owner_q && if_flush) drop_d = 1'b1;
        if (cnt_q == 8'd0) begin
          // Memory data is valid in this final WAIT cycle only.
          if (owner_q) begin
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else if (!(drop_q || if_flush)) begin
            if_rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign if_ready   = (state_q == S_RESP) && !owner_q && !drop_q;
  assign d_ready    = (state_q == S_RESP) && owner_q;
  assign if_stall   = if_req & ~if_ready;
  assign d_stall    = d_req & ~d_ready;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;
  assign dbg_streak = streak_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int MAXS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, if_flush, if_ready, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_streak;

  mem_port_arbiter #(.LAT(LAT), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory device: answers LAT cycles after the strobe, junk otherwise.
  logic [31:0] dev_mem [logic [31:0]];
  int          dev_due = -1;
  logic [31:0] dev_addr;

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_word(a);
  endfunction

  // Reference model: one transaction record plus the architectural results.
  logic [31:0] sh_mem [logic [31:0]];
  logic        m_busy, m_owner, m_we, m_drop;
  logic [31:0] m_addr, m_wdata;
  int          m_g, m_streak;
  logic        h_we;
  logic [31:0] h_addr, h_wdata, e_if_rdata, e_d_rdata;
  logic        last_if_rdy, last_d_rdy;

  function automatic logic [31:0] sh_read(input logic [31:0] a);
    if (sh_mem.exists(a)) return sh_mem[a];
    return init_word(a);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_we = 0; m_drop = 0; m_addr = 0; m_wdata = 0;
    m_g = 0; m_streak = 0; h_we = 0; h_addr = 0; h_wdata = 0;
    e_if_rdata = 0; e_d_rdata = 0; dev_due = -1;
  endtask

  task automatic model_step();
    int          ph;
    logic [1:0]  es;
    logic        eif, ed;
    ph = m_busy ? (cyc - m_g) : 0;
    if (!m_busy)           es = 2'd0;
    else if (ph == 1)      es = 2'd1;
    else if (ph <= LAT + 1) es = 2'd2;
    else                   es = 2'd3;
    if (m_busy && !m_owner && ph >= 1 && ph <= LAT + 1 && if_flush) m_drop = 1;
    eif = m_busy && (ph == LAT + 2) && !m_owner && !m_drop;
    ed  = m_busy && (ph == LAT + 2) && m_owner;
    check_eq("state",     {30'd0, dbg_state}, {30'd0, es});
    check_eq("streak",    {24'd0, dbg_streak}, 32'(m_streak));
    check_eq("mem_en",    {31'd0, mem_en}, {31'd0, m_busy && ph == 1});
    check_eq("mem_we",    {31'd0, mem_we}, {31'd0, h_we});
    check_eq("mem_addr",  mem_addr, h_addr);
    check_eq("mem_wdata", mem_wdata, h_wdata);
    check_eq("if_ready",  {31'd0, if_ready}, {31'd0, eif});
    check_eq("d_ready",   {31'd0, d_ready}, {31'd0, ed});
    check_eq("if_rdata",  if_rdata, e_if_rdata);
    check_eq("d_rdata",   d_rdata, e_d_rdata);
    check_eq("if_stall",  {31'd0, if_stall}, {31'd0, if_req & ~eif});
    check_eq("d_stall",   {31'd0, d_stall}, {31'd0, d_req & ~ed});
    // Results land at the end of the last WAIT cycle.
    if (m_busy && ph == LAT + 1) begin
      if (!m_owner && !m_drop) e_if_rdata = sh_read(m_addr);
      if (m_owner && !m_we)    e_d_rdata  = sh_read(m_addr);
    end
    if (m_busy && ph == LAT + 2) begin
      m_busy = 0;
    end else if (!m_busy && rst) begin
      if (d_req && (!if_req || m_streak < MAXS)) begin
        m_busy = 1; m_owner = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
        m_streak = if_req ? m_streak + 1 : 0;
        if (d_we) sh_mem[d_addr] = d_wdata;
      end else if (if_req) begin
        m_busy = 1; m_owner = 0; m_we = 0; m_addr = if_addr; m_wdata = 0;
        m_streak = 0;
      end
      if (m_busy) begin
        m_g = cyc; m_drop = 0; h_we = m_we; h_addr = m_addr; h_wdata = m_wdata;
      end
    end
  endtask

  // Checks one cycle at the falling edge, then advances to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    last_if_rdy = if_ready;
    last_d_rdy  = d_ready;
    if (mem_en === 1'b1) begin
      dev_due  = cyc + LAT;
      dev_addr = mem_addr;
      if (mem_we) dev_mem[mem_addr] = mem_wdata;
    end
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = (cyc == dev_due) ? dev_read(dev_addr) : $urandom();
  endtask

  // ---------------- driver tasks ----------------
  task automatic finish_data();
    for (int k = 0; k < 4 * (LAT + 3) && !last_d_rdy; k++) tick();
    check_eq("d_done", {31'd0, last_d_rdy}, 32'd1);
    d_req = 0; d_we = 0;
    tick();
  endtask

  task automatic finish_fetch();
    for (int k = 0; k < 4 * (LAT + 3) && !last_if_rdy; k++) tick();
    check_eq("if_done", {31'd0, last_if_rdy}, 32'd1);
    if_req = 0;
    tick();
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [3:0] w;
    w = 4'($urandom_range(0, 15));
    return {26'd0, w, 2'b00};
  endfunction

  task automatic drive_random();
    if_flush = ($urandom_range(0, 19) == 0);
    if (!if_req || last_if_rdy) begin
      if_req  = ($urandom_range(0, 2) != 0);
      if_addr = rnd_addr();
    end else if (if_flush) begin
      if_addr = rnd_addr();
    end
    if (!d_req || last_d_rdy) begin
      d_req   = ($urandom_range(0, 1) != 0);
      d_we    = ($urandom_range(0, 1) != 0);
      d_addr  = rnd_addr();
      d_wdata = $urandom();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          nd;
    logic        fseen;
    logic [31:0] saved;
    rst = 0; if_req = 0; if_addr = 0; if_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    last_if_rdy = 0; last_d_rdy = 0;
    model_reset();
    tick(); tick();
    rst = 1;
    tick();

    // Single fetch
    dev_mem[32'h10] = 32'h8C01_0004; sh_mem[32'h10] = 32'h8C01_0004;
    if_req = 1; if_addr = 32'h10;
    for (int k = 0; k < LAT + 2; k++) tick();
    check_eq("tp_fetch_ready", {31'd0, if_ready}, 32'd1);
    check_eq("tp_fetch_data", if_rdata, 32'h8C01_0004);
    tick();
    if_req = 0;
    tick();

    // Contention: data first, fetch right after
    if_req = 1; if_addr = 32'h14; d_req = 1; d_we = 0; d_addr = 32'h40;
    for (int k = 0; k < 4; k++) tick();
    check_eq("tp_cont_dready", {31'd0, d_ready}, 32'd1);
    tick();
    d_req = 0;
    for (int k = 0; k < 4; k++) tick();
    check_eq("tp_cont_ifready", {31'd0, if_ready}, 32'd1);
    tick();
    if_req = 0;
    tick();

    // Starvation bound
    nd = 0; fseen = 0;
    if_req = 1; if_addr = 32'h24; d_req = 1; d_we = 0; d_addr = 32'h4C;
    for (int k = 0; k < 7 * (LAT + 3); k++) begin
      if (fseen) if_req = 0;
      tick();
      if (last_d_rdy && !fseen) nd++;
      if (last_if_rdy) fseen = 1;
    end
    check_eq("starve_data_grants", 32'(nd), 32'(MAXS));
    check_eq("starve_fetch_seen", {31'd0, fseen}, 32'd1);
    finish_data();

    // Store leaves d_rdata alone
    dev_mem[32'h30] = 32'h1234; sh_mem[32'h30] = 32'h1234;
    d_req = 1; d_we = 0; d_addr = 32'h30;
    finish_data();
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    tick();
    check_eq("tp_store_en", {31'd0, mem_en}, 32'd1);
    check_eq("tp_store_we", {31'd0, mem_we}, 32'd1);
    check_eq("tp_store_addr", mem_addr, 32'h20);
    check_eq("tp_store_wdata", mem_wdata, 32'hDEAD_BEEF);
    finish_data();
    check_eq("tp_store_rdata", d_rdata, 32'h1234);

    // Flush during WAIT
    saved = e_if_rdata;
    if_req = 1; if_addr = 32'h08;
    tick(); tick();
    if_flush = 1; if_addr = 32'h10;
    tick();
    if_flush = 0;
    tick();
    check_eq("tp_flush_noready", {31'd0, if_ready}, 32'd0);
    check_eq("tp_flush_rdata", if_rdata, saved);
    tick();
    finish_fetch();

    // Reset in the middle of an access
    d_req = 1; d_we = 0; d_addr = 32'h44;
    tick(); tick();
    #2;
    rst = 0;
    #1;
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);
    check_eq("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    model_reset();
    d_req = 0; if_req = 1; if_addr = 32'h18;
    tick();
    rst = 1;
    tick();
    check_eq("tp_rst_issue_en", {31'd0, mem_en}, 32'd1);
    check_eq("tp_rst_issue_addr", mem_addr, 32'h18);
    finish_fetch();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      drive_random();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
